// File: rtl/cb_pingpong_transpose_if.sv
// cb_pingpong_transpose_if: stream bundle for the corner-turn buffer.
// master drives input beats and output ready; slave is the buffer.
interface cb_pingpong_transpose_if #(
  parameter int LANES = 8,
  parameter int DW    = 10
);
  logic                in_valid;
  logic                in_ready;
  logic [LANES*DW-1:0] dinre;
  logic [LANES*DW-1:0] dinim;
  logic                out_valid;
  logic                out_ready;
  logic [LANES*DW-1:0] doutre;
  logic [LANES*DW-1:0] doutim;
  logic                out_last;
  logic                busy;

  modport master (
    output in_valid, dinre, dinim, out_ready,
    input  in_ready, out_valid, doutre, doutim, out_last, busy
  );

  modport slave (
    input  in_valid, dinre, dinim, out_ready,
    output in_ready, out_valid, doutre, doutim, out_last, busy
  );
endinterface

// File: rtl/cb_pingpong_transpose.sv
// cb_pingpong_transpose: ping-pong LANESxLANES complex corner turn.
// CB_BITREV_EN: emit columns in bit-reversed order on the read side.
module cb_pingpong_transpose #(
  parameter int LANES = 8,
  parameter int DW    = 10
) (
  input logic                   clk,
  input logic                   rst_n,
  input logic                   flush,
  cb_pingpong_transpose_if.slave bus
);
  localparam int AW = $clog2(LANES);
  typedef logic [AW-1:0] cnt_t;
  localparam cnt_t LAST = cnt_t'(LANES - 1);

  logic [DW-1:0] re_q [2][LANES][LANES];
  logic [DW-1:0] im_q [2][LANES][LANES];

  logic [1:0] full_q, full_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  cnt_t       wr_cnt_q, wr_cnt_d;
  cnt_t       rd_cnt_q, rd_cnt_d;
  cnt_t       col;
  logic       wr_fire, rd_fire;

  assign bus.in_ready  = !full_q[wr_bank_q];
  assign bus.out_valid = full_q[rd_bank_q];
  assign bus.out_last  = bus.out_valid && (rd_cnt_q == LAST);
  assign bus.busy      = (|full_q) || (wr_cnt_q != '0);

  assign wr_fire = bus.in_valid && bus.in_ready;
  assign rd_fire = bus.out_valid && bus.out_ready;

`ifdef CB_BITREV_EN
  // reverse the column index bits for natural-order FFT output
  always_comb begin
    col = '0;
    for (int b = 0; b < AW; b++) begin
      col[b] = rd_cnt_q[AW-1-b];
    end
  end
`else
  assign col = rd_cnt_q;
`endif

  // pointer and full-flag update; flush overrides any handshake
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    if (flush) begin
      full_d    = '0;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
      wr_cnt_d  = '0;
      rd_cnt_d  = '0;
    end else begin
      if (wr_fire) begin
        wr_cnt_d = wr_cnt_q + cnt_t'(1);
        if (wr_cnt_q == LAST) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = !wr_bank_q;
        end
      end
      if (rd_fire) begin
        rd_cnt_d = rd_cnt_q + cnt_t'(1);
        if (rd_cnt_q == LAST) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = !rd_bank_q;
        end
      end
    end
  end

  // control state with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  // store an accepted beat as one row of the write bank
  always_ff @(posedge clk) begin
    if (wr_fire && !flush) begin
      for (int c = 0; c < LANES; c++) begin
        re_q[wr_bank_q][wr_cnt_q][c] <= bus.dinre[c*DW +: DW];
        im_q[wr_bank_q][wr_cnt_q][c] <= bus.dinim[c*DW +: DW];
      end
    end
  end

  // output beat is one column of the read bank, row r on lane r
  always_comb begin
    bus.doutre = '0;
    bus.doutim = '0;
    for (int r = 0; r < LANES; r++) begin
      bus.doutre[r*DW +: DW] = re_q[rd_bank_q][r][col];
      bus.doutim[r*DW +: DW] = im_q[rd_bank_q][r][col];
    end
  end
endmodule

// File: doc/cb_pingpong_transpose.md
Name: cb_pingpong_transpose

Overview:
- Parametrised corner-turn buffer for the FFT datapath.
- Accepts a block of LANES input beats, each carrying LANES complex samples, and emits the same block transposed: output beat j carries lane j of every input beat.
- Two ping-pong banks let one block fill while the previous one drains, so sustained throughput is one beat per cycle with no idle gap.
- Sits between FFT stages, in place of a single-bank read-then-send corner-turn buffer, and adds valid/ready flow control on both sides.

Parameters:
- LANES, 8, samples per beat and beats per block; power of two, at least 2.
- DW, 10, bit width of each real and each imaginary sample.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of both banks and all counters.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- dinre  in  LANES*DW  real samples; lane i at bits [i*DW +: DW].
- dinim  in  LANES*DW  imaginary samples, same packing.
- out_valid  out  1  output beat valid.
- out_ready  in  1  output beat consumed when out_valid && out_ready.
- doutre  out  LANES*DW  real transposed beat; lane i at bits [i*DW +: DW].
- doutim  out  LANES*DW  imaginary transposed beat.
- out_last  out  1  high on the final beat (j = LANES-1) of an output block.
- busy  out  1  high while either bank is non-empty.

Behaviour:
- Reset is asynchronous, active-low, on clk's domain; polarity and synchronicity are fixed.
- Storage: 2 banks, each LANES x LANES complex words. Each bank has a full flag.
- Pointers: wr_bank, wr_cnt (log2 LANES bits) and rd_bank, rd_cnt (log2 LANES bits).
- Reset and flush both clear the following to 0: full flags, wr_bank, wr_cnt, rd_bank, rd_cnt. Storage contents are don't-care.
- Resulting output values after reset or flush: in_ready=1, out_valid=0, out_last=0, busy=0, doutre=doutim=don't-care (a bench must not check data while out_valid=0).
- Write side:
  - in_ready = !full[wr_bank].
  - On acceptance, input lane c is stored at bank[wr_bank][row wr_cnt][col c], and wr_cnt increments.
  - When wr_cnt==LANES-1 is accepted: full[wr_bank] is set, wr_cnt wraps to 0 and wr_bank toggles.
- Read side:
  - out_valid = full[rd_bank].
  - Output lane r = bank[rd_bank][row r][col rd_cnt]. This is a combinational mux from storage; there is no output register.
  - On consume, rd_cnt increments.
  - On consume with rd_cnt==LANES-1: full[rd_bank] is cleared, rd_cnt wraps and rd_bank toggles.
  - out_last = out_valid && rd_cnt==LANES-1.
- Latency: the first output beat of a block is valid the cycle after its last input beat is accepted.
- Stall: while out_valid && !out_ready, doutre, doutim and out_last hold stable. Writes target only the other bank, so held data is never disturbed.
- Simultaneous events:
  - A write completing one bank and a read completing the other in the same cycle both take effect; the set and clear hit different banks.
  - Read and write never touch the same bank while the read is active.
- Both banks full: in_ready=0. Input stalls until the draining bank is released; in_ready rises the cycle after that bank's final beat is consumed.
- Flush has priority over any concurrent handshake in that cycle: the accepted or consumed beat is discarded and counters restart at 0. in_ready=1 the cycle after flush.
- A partial input block (wr_cnt != 0) stays pending indefinitely. It is never emitted until completed.
- Reset mid-block discards all data immediately; the asynchronous clear applies.
- busy = full[0] || full[1] || wr_cnt != 0.

Optional Feature:
- Macro: CB_BITREV_EN.
- Defined: the read side emits columns in bit-reversed order. Output beat j carries column bitrev(rd_cnt) over log2(LANES) bits, giving natural-order FFT output. out_last stays tied to rd_cnt==LANES-1.
- Undefined: columns are emitted in natural order 0..LANES-1, as described above.

Test Plan:
- Reset, LANES=8, DW=10: input beat k lane c = k*8+c on re, and its negation on im, back-to-back with out_ready=1 -> out_valid rises 1 cycle after beat 7 is accepted; output beat j lane r = r*8+j; out_last on beat 7 only.
- Continuous 4 blocks, in_valid=1 and out_ready=1 throughout -> in_ready never drops; 32 output beats on 32 consecutive cycles after the initial 8-cycle latency; data transposed per block.
- out_ready=0 while 2 blocks are written -> in_ready=0 after the 16th beat; output beat 0 holds stable; raising out_ready drains 16 beats in order; in_ready returns the cycle after beat 7 of block 0 is consumed.
- flush pulsed after 3 input beats, concurrent with an accepted beat -> next cycle in_ready=1, busy=0, out_valid=0; the following full block is emitted with no residue.
- rst_n asserted mid-drain at beat 4 -> out_valid=0 and in_ready=1 immediately; a fresh block then transposes correctly.
- CB_BITREV_EN defined, same stimulus as scenario 1 -> output beat order is columns 0,4,2,6,1,5,3,7.
